aes_enc_core128: RTL and testbench
==================================

Name: aes_enc_core128

Overview:
- Iterative AES-128 encryption datapath that consumes the round-key words produced by the team's AES-128 key expander (CLK, ld, KEY in; Wk0..Wk3 out, new round key every 4 cycles).
- Drives the expander's ld and processes one 32-bit state column per cycle, so one round takes 4 cycles and lines up exactly with the expander's key cadence.
- Feeds the CMAC chaining logic downstream.

Parameters:
- None. Fixed AES-128: 10 rounds, 4 cycles per round.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- din  in  128  plaintext block; captured in the start cycle.
- key_ld  out  1  connects to expander ld. Combinational: start && IDLE.
- Wk0  in  32  round-key word 0 from the expander (column 0).
- Wk1  in  32  round-key word 1 (column 1).
- Wk2  in  32  round-key word 2 (column 2).
- Wk3  in  32  round-key word 3 (column 3).
- busy  out  1  high while an encryption is in flight.
- done  out  1  one-cycle pulse when dout is valid.
- dout  out  128  ciphertext; held until the next done.

Behaviour:
- Byte mapping:
  - Column c = bits [127-32c -: 32]; row r = bits [31-8r -: 8] within the column.
  - Wk0 = column 0, matching the expander's KEY[127:96].
- Reset (RST_N low, asynchronous):
  - FSM goes to IDLE; busy=0, done=0, key_ld=0, dout=0.
  - Round and phase counters clear to 0.
  - The expander has no reset; the next start reloads it via key_ld.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 → capture din into state; key_ld=1 this cycle; go to RUN; round=0, phase=0.
  - start=0 → stay.
- Key timing: cycle T is the start cycle. Key Ki is visible on Wk0..Wk3 during cycles T+1+4i .. T+4+4i, for i = 0..10.
- RUN, one column per cycle:
  - Cycle T+1+4i+p: round=i, phase=p.
  - Compute column p of the next state into a holding buffer, reading only the old state register.
  - Round 0: col = state[p] ^ Wk_p.
  - Rounds 1-9: col = MixColumns(SubBytes(ShiftRows column p)) ^ Wk_p. ShiftRows: row r of output column p is row r of old column (p+r) mod 4.
  - Round 10: col = SubBytes(ShiftRows column p) ^ Wk_p, with no MixColumns.
  - Phase 3: commit {buf0, buf1, buf2, col3} to state. Phase wraps 3→0 and round increments.
  - Round 10 phase 3 (cycle T+44): also load dout with the committed value; go to FIN.
- Datapath resources:
  - 4 aes_sbox instances (ports .a, .d), one per row of the active column.
  - MixColumns uses xtime over GF(2^8), polynomial 0x11b.
- FIN (cycle T+45):
  - done=1, busy=0, dout valid.
  - Acts as IDLE for start: start=1 in FIN is accepted (back-to-back), with key_ld asserted.
  - Next cycle: IDLE, or RUN if start was accepted.
- busy: high from T+1 through T+44 inclusive. Total latency is start cycle to done = 45 cycles.
- start while busy: ignored; key_ld stays 0; no effect on the operation in flight.
- din changes after the start cycle: no effect.
- dout holds its value across IDLE and across a new operation until the next done.
- Reset mid-operation: immediate abort; dout=0; no done pulse. The next start behaves as from power-up.

Test Plan:
- FIPS-197 C.1: KEY=000102030405060708090a0b0c0d0e0f, din=00112233445566778899aabbccddeeff → done exactly at T+45, dout=69c4e0d86a7b0430d8cdb78070b4c55a, busy high T+1..T+44.
- FIPS-197 App. B: KEY=2b7e151628aed2a6abf7158809cf4f3c, din=3243f6a8885a308d313198a2e0370734 → dout=3925841d02dc09fbdc118597196a0b32. After round 1 commit (T+8), state=a49c7ff2689f352b6b5bea43026a5049.
- Start ignored while busy: pulse start with a different din at T+10 and T+30 → key_ld stays 0, result still equals the C.1 vector, single done.
- Back-to-back: assert start in the FIN cycle with the App. B vectors → key_ld=1 that cycle, second done 45 cycles later with the correct ciphertext, no idle gap.
- Reset mid-op: drop RST_N at T+20 → busy=0, done=0, dout=0 asynchronously. After release, run C.1 → correct dout, latency 45.
- Data hold: after done, toggle din with no start for 100 cycles → dout stable, done stays 0.

Source files
------------

// File: rtl/aes_enc_core128.sv
// Iterative AES-128 encryption core: one state column per cycle, four cycles per round,
// 45 cycles from start to done. Round keys come from an external expander loaded by key_ld.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  // Multiplicative inverse as a^254 (product of a^2, a^4, ..., a^128), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  assign d = sbox(a);
endmodule

module aes_enc_core128 (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [127:0] din,
  output logic         key_ld,
  input  logic [31:0]  Wk0,
  input  logic [31:0]  Wk1,
  input  logic [31:0]  Wk2,
  input  logic [31:0]  Wk3,
  output logic         busy,
  output logic         done,
  output logic [127:0] dout
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} fsm_t;

  fsm_t         fsm;
  logic [127:0] st;
  logic [31:0]  buf0, buf1, buf2;
  logic [3:0]   round;
  logic [1:0]   phase;

  logic [7:0]   byt [4][4];
  logic [7:0]   sb_in [4];
  logic [7:0]   sb_out [4];
  logic [31:0]  wk, plain, mix, col;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the active column reads old column (phase + r) mod 4: ShiftRows folded into the select.
  always_comb begin
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        byt[c][r] = st[127 - 32*c - 8*r -: 8];
    for (int r = 0; r < 4; r++)
      sb_in[r] = byt[phase + 2'(r)][r];
  end

  for (genvar r = 0; r < 4; r++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[r]), .d(sb_out[r]));
  end

  always_comb begin
    case (phase)
      2'd0:    wk = Wk0;
      2'd1:    wk = Wk1;
      2'd2:    wk = Wk2;
      default: wk = Wk3;
    endcase
    plain = {byt[phase][0], byt[phase][1], byt[phase][2], byt[phase][3]};
    mix = {xt(sb_out[0]) ^ xt(sb_out[1]) ^ sb_out[1] ^ sb_out[2] ^ sb_out[3],
           sb_out[0] ^ xt(sb_out[1]) ^ xt(sb_out[2]) ^ sb_out[2] ^ sb_out[3],
           sb_out[0] ^ sb_out[1] ^ xt(sb_out[2]) ^ xt(sb_out[3]) ^ sb_out[3],
           xt(sb_out[0]) ^ sb_out[0] ^ sb_out[1] ^ sb_out[2] ^ xt(sb_out[3])};
    if (round == 4'd0)
      col = plain ^ wk;
    else if (round == 4'd10)
      col = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]} ^ wk;
    else
      col = mix ^ wk;
  end

  assign key_ld = start && RST_N && (fsm == IDLE || fsm == FIN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fsm   <= IDLE;
      st    <= '0;
      buf0  <= '0;
      buf1  <= '0;
      buf2  <= '0;
      round <= '0;
      phase <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
    end else begin
      case (fsm)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            st    <= din;
            round <= '0;
            phase <= '0;
            busy  <= 1'b1;
            fsm   <= RUN;
          end else begin
            fsm <= IDLE;
          end
        end
        RUN: begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0: buf0 <= col;
            2'd1: buf1 <= col;
            2'd2: buf2 <= col;
            default: begin
              st <= {buf0, buf1, buf2, col};
              if (round == 4'd10) begin
                dout <= {buf0, buf1, buf2, col};
                done <= 1'b1;
                busy <= 1'b0;
                fsm  <= FIN;
              end else begin
                round <= round + 4'd1;
              end
            end
          endcase
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_enc_core128.sv
// Randomized bench for aes_enc_core128 with a behavioural AES-128 model, a key-expander model
// driving Wk0..Wk3, and a per-cycle compare of busy/done/dout/key_ld.

module tb_aes_enc_core128;
  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         start = 1'b0;
  logic [127:0] din = '0;
  logic         key_ld;
  logic [31:0]  Wk0 = '0, Wk1 = '0, Wk2 = '0, Wk3 = '0;
  logic         busy, done;
  logic [127:0] dout;

  aes_enc_core128 dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .din(din), .key_ld(key_ld),
    .Wk0(Wk0), .Wk1(Wk1), .Wk2(Wk2), .Wk3(Wk3),
    .busy(busy), .done(done), .dout(dout)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [127:0] row;
    int lo;
    row = sbox_rows[x[7:4]];
    lo  = int'(x[3:0]);
    return row[127 - 8*lo -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int b);
    return v[127 - 8*b -: 8];
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int i);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int j = 0; j < 4; j++) w[j] = key[127 - 32*j -: 32];
    for (int j = 4; j < 44; j++) begin
      t = w[j-1];
      if (j % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[j] = w[j-4] ^ t;
    end
    return {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
  endfunction

  // Byte b = 4*column + row, most significant byte first.
  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ round_key(key, 0);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int b = 0; b < 16; b++) t[127 - 8*b -: 8] = sb(gb(s, b));
      s = t;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127 - 8*(4*c + r) -: 8] = gb(s, 4*((c + r) % 4) + r);
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
          t[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        s = t;
      end
      s = s ^ round_key(key, rnd);
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expander model: key Ki is presented during cycles T+1+4i .. T+4+4i after a load in cycle T.
  logic [127:0] cur_key = '0;
  logic [127:0] exp_key = '0;
  logic         ld_seen = 1'b0;
  int           ecnt = 1000;
  always @(negedge CLK) ld_seen <= key_ld;
  always @(posedge CLK) begin
    if (ld_seen) begin
      ecnt = 0;
      exp_key = cur_key;
    end else if (ecnt < 1000) begin
      ecnt++;
    end
    #1;
    if (ecnt < 44) {Wk0, Wk1, Wk2, Wk3} = round_key(exp_key, ecnt / 4);
    else           {Wk0, Wk1, Wk2, Wk3} = rand128();
  end

  // Timing model: an op accepted in cycle T is busy T+1..T+44 and completes in T+45.
  int           t_start = -1;
  logic [127:0] cur_ct = '0;
  logic [127:0] e_dout = '0;
  int           done_cnt = 0;
  int           last_done_cyc = 0;
  logic         idle_like, e_busy, e_done, e_kld;
  always @(negedge CLK) begin
    if (RST_N) begin
      idle_like = (t_start < 0) || (cyc == t_start + 45);
      e_busy    = (t_start >= 0) && (cyc >= t_start + 1) && (cyc <= t_start + 44);
      e_done    = (t_start >= 0) && (cyc == t_start + 45);
      e_kld     = start && idle_like;
      if (e_done) e_dout = cur_ct;
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("dout", dout, e_dout);
      chk("key_ld", key_ld, e_kld);
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (e_done) t_start = -1;
      if (e_kld) begin
        t_start = cyc;
        cur_ct  = aes_model(cur_key, din);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic step_to(input int target);
    for (int k = 0; k < 200 && cyc < target; k++) step();
  endtask

  task automatic go(input logic [127:0] key, input logic [127:0] pt, output int t);
    cur_key = key;
    din     = pt;
    start   = 1'b1;
    t       = cyc;
    step();
    start   = 1'b0;
    din     = rand128();
  endtask

  task automatic wait_done(input int c0, input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge CLK);
      #1;
      if (done_cnt != c0) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: no done within %0d cycles (cycle %0d)", bound, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t, t2, c0;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dout", dout, 0);
    chk("reset_key_ld", key_ld, 0);
    RST_N = 1'b1;
    step();

    chk("model_c1", aes_model(K1, P1), C1);
    chk("model_appb", aes_model(K2, P2), C2);
    chk("model_appb_rk10", round_key(K2, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // FIPS-197 C.1
    go(K1, P1, t);
    c0 = done_cnt;
    wait_done(c0, 60);
    chki("c1_latency", last_done_cyc - t, 45);
    chk("c1_dout", dout, C1);

    // FIPS-197 Appendix B with a look at the state after round 1
    step();
    go(K2, P2, t);
    c0 = done_cnt;
    repeat (8) step();
    @(negedge CLK);
    #1;
    chk("appb_round1_state", dut.st, 128'ha49c7ff2689f352b6b5bea43026a5049);
    wait_done(c0, 60);
    chk("appb_dout", dout, C2);

    // start pulses while busy must be ignored
    step();
    go(K1, P1, t);
    c0 = done_cnt;
    for (int j = 0; j < 2; j++) begin
      step_to(t + (j == 0 ? 10 : 30));
      start = 1'b1;
      din = rand128();
      cur_key = rand128();
      @(negedge CLK);
      #1;
      chk("busy_start_key_ld", key_ld, 0);
      step();
      start = 1'b0;
    end
    wait_done(c0, 60);
    chki("ignore_latency", last_done_cyc - t, 45);
    chk("ignore_dout", dout, C1);
    repeat (5) step();
    chki("ignore_done_count", done_cnt - c0, 1);

    // back-to-back: new start in the FIN cycle
    go(K1, P1, t);
    step_to(t + 45);
    cur_key = K2;
    din = P2;
    start = 1'b1;
    @(negedge CLK);
    #1;
    chk("b2b_key_ld", key_ld, 1);
    chk("b2b_first_done", done, 1);
    chk("b2b_first_dout", dout, C1);
    step();
    start = 1'b0;
    t2 = t + 45;
    c0 = done_cnt;
    wait_done(c0, 60);
    chki("b2b_latency", last_done_cyc - t2, 45);
    chk("b2b_dout", dout, C2);

    // reset in the middle of an operation
    step();
    go(K2, P2, t);
    step_to(t + 20);
    RST_N = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dout", dout, 0);
    t_start = -1;
    e_dout = '0;
    repeat (3) step();
    RST_N = 1'b1;
    step();
    go(K1, P1, t);
    c0 = done_cnt;
    wait_done(c0, 60);
    chki("postrst_latency", last_done_cyc - t, 45);
    chk("postrst_dout", dout, C1);

    // data hold: din toggles with no start
    c0 = done_cnt;
    for (int k = 0; k < 100; k++) begin
      din = rand128();
      step();
    end
    chk("hold_dout", dout, C1);
    chki("hold_done_count", done_cnt - c0, 0);

    // random traffic: sporadic starts, random keys and data every cycle
    for (int k = 0; k < 1500; k++) begin
      start = ($urandom_range(0, 15) == 0);
      din = rand128();
      cur_key = rand128();
      step();
    end
    start = 1'b0;
    repeat (50) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
